// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and sizing helpers
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index width for a register bank; a single-register bank still needs one bit
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// rtl/axi4_lite_addr_decode.sv - byte address to register index decode with range check
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0]          addr,
  output logic [idx_width(NUM_REGS)-1:0] idx,
  output logic                           hit
);

  localparam int                    IDX_W      = idx_width(NUM_REGS);
  localparam int                    SHIFT      = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  // Word offset from the bank base; byte-lane bits are dropped by the shift
  logic [ADDR_WIDTH-1:0] word;

  assign word = (addr - BASE_ADDR) >> SHIFT;
  assign hit  = (addr >= BASE_ADDR) && (word < NUM_REGS_A);
  assign idx  = word[IDX_W-1:0];

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// rtl/axi4_lite_regfile_slave.sv - AXI4-Lite slave terminating into a flat register bank
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDX_W = idx_width(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_full_q;
  logic                  w_full_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IDX_W-1:0] aw_idx;
  logic             aw_hit;
  logic [IDX_W-1:0] ar_idx;
  logic             ar_hit;
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;

  // The write path decodes the latched address so AW may arrive well before W
  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)
  ) u_aw_decode (
    .addr(awaddr_q), .idx(aw_idx), .hit(aw_hit)
  );

  // The read path decodes the live address because data is captured at the handshake
  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)
  ) u_ar_decode (
    .addr(araddr), .idx(ar_idx), .hit(ar_hit)
  );

  assign awready = !reset && !aw_full_q && !bvalid_q;
  assign wready  = !reset && !w_full_q && !bvalid_q;
  assign arready = !reset && !rvalid_q;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign wr_pulse = wr_pulse_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  // Write channel: collect AW and W in any order, commit once both are held, then respond
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (aw_hs) begin
        awaddr_q  <= awaddr;
        aw_full_q <= 1'b1;
      end
      if (w_hs) begin
        wdata_q  <= wdata;
        w_full_q <= 1'b1;
      end
      if (commit) begin
        if (aw_hit) begin
          regs_q[aw_idx]     <= wdata_q;
          wr_pulse_q[aw_idx] <= 1'b1;
          bresp_q            <= RESP_OKAY;
        end else begin
          bresp_q <= RESP_SLVERR;
        end
        bvalid_q  <= 1'b1;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end else if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: sample the bank on the AR handshake and hold the beat until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= ar_hit ? regs_q[ar_idx] : '0;
    end else if (rvalid_q && rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// tb/tb_axi4_lite_regfile_slave.sv - self-checking bench for the AXI4-Lite register file slave
module tb_axi4_lite_regfile_slave;

  logic         clk;
  logic         reset;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] reg_out;
  logic [15:0]  wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [16];

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endfunction

  // Full write transaction; w_dly/aw_dly set per-channel start cycles, hold delays bready
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int w_dly, input int aw_dly, input int hold);
    int   cyc;
    int   lat;
    bit   aw_done;
    bit   w_done;
    bit   aw_hs;
    bit   w_hs;
    bit   hit;
    int   idx;
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
    hit       = (addr < 32'd64);
    idx       = int'(addr / 4);
    exp_resp  = hit ? 2'b00 : 2'b10;
    exp_pulse = hit ? (16'd1 << idx) : 16'd0;
    cyc = 0; aw_done = 0; w_done = 0; bready = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awaddr  = addr;
      wdata   = data;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      step();
      cyc++;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
    end
    awvalid = 0;
    wvalid  = 0;
    chk("wr_handshakes", {aw_done, w_done}, 2'b11);
    lat = 0;
    while (!bvalid && lat < 20) begin
      step();
      lat++;
    end
    chk("wr_latency", lat, 1);
    chk("bresp", bresp, exp_resp);
    chk("wr_pulse", wr_pulse, exp_pulse);
    if (hit) mdl[idx] = data;
    chk("reg_out_after_wr", reg_out, model_flat());
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bvalid_held", bvalid, 1'b1);
      chk("bresp_held", bresp, exp_resp);
      chk("awready_blocked", awready, 1'b0);
      chk("wready_blocked", wready, 1'b0);
      chk("wr_pulse_single", wr_pulse, 16'd0);
    end
    bready = 1;
    step();
    bready = 0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("wr_pulse_clear", wr_pulse, 16'd0);
  endtask

  task automatic do_read(input logic [31:0] addr);
    int   cyc;
    bit   hit;
    int   idx;
    logic [31:0] exp_data;
    hit      = (addr < 32'd64);
    idx      = int'(addr / 4);
    exp_data = hit ? mdl[idx] : 32'h0;
    araddr  = addr;
    arvalid = 1;
    rready  = 0;
    cyc = 0;
    while (!arready && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    arvalid = 0;
    chk("rvalid", rvalid, 1'b1);
    chk("rdata", rdata, exp_data);
    chk("rresp", rresp, hit ? 2'b00 : 2'b10);
    rready = 1;
    step();
    rready = 0;
    chk("rvalid_clear", rvalid, 1'b0);
  endtask

  initial begin
    reset = 1; awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    model_clear();
    step();
    step();
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_wr_pulse", wr_pulse, 16'd0);
    chk("rst_reg_out", reg_out, 512'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    reset = 0;
    step();
    chk("idle_readies", {awready, wready, arready}, 3'b111);

    // AW and W together, then read back
    do_write(32'h8, 32'hDEADBEEF, 0, 0, 0);
    do_read(32'h8);

    // W three cycles ahead of AW
    do_write(32'h4, 32'h12345678, 0, 3, 0);
    chk("reg1_slice", reg_out[63:32], 32'h12345678);

    // Out-of-range write and read
    do_write(32'h40, 32'hA5A5A5A5, 0, 0, 0);
    do_read(32'h40);

    // Back-pressured B channel; next AW only after B handshake
    do_write(32'h14, 32'h0BADF00D, 1, 0, 5);
    chk("awready_after_b", awready, 1'b1);
    do_write(32'h18, 32'h11112222, 0, 0, 0);

    // Read and write of register 3 sampled on the same edge
    do_write(32'hC, 32'h1, 0, 0, 0);
    awaddr = 32'hC; wdata = 32'h2; awvalid = 1; wvalid = 1;
    chk("same_edge_aw_w_ready", {awready, wready}, 2'b11);
    step();
    awvalid = 0; wvalid = 0;
    araddr = 32'hC; arvalid = 1;
    chk("same_edge_arready", arready, 1'b1);
    step();
    arvalid = 0;
    chk("same_edge_bvalid", bvalid, 1'b1);
    chk("same_edge_rvalid", rvalid, 1'b1);
    chk("same_edge_old_data", rdata, 32'h1);
    mdl[3] = 32'h2;
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    do_read(32'hC);

    // Reset one cycle after an AW handshake, before W
    awaddr = 32'h10; awvalid = 1;
    step();
    awvalid = 0;
    reset = 1;
    step();
    reset = 0;
    model_clear();
    step();
    chk("midrst_bvalid", bvalid, 1'b0);
    chk("midrst_reg_out", reg_out, 512'd0);
    chk("midrst_awready", awready, 1'b1);
    wdata = 32'hCAFEF00D; wvalid = 1;
    chk("midrst_wready", wready, 1'b1);
    step();
    wvalid = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("lone_w_no_bvalid", bvalid, 1'b0);
      chk("lone_w_no_pulse", wr_pulse, 16'd0);
      chk("lone_w_no_write", reg_out, 512'd0);
    end
    reset = 1;
    step();
    reset = 0;
    step();

    // Randomized traffic, including unaligned and out-of-range addresses
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 79));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)));
      else
        do_read(a);
    end
    chk("final_reg_out", reg_out, model_flat());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
